key_event_filter: RTL and testbench
===================================

# key_event_filter

Debounces and de-duplicates raw keypad scan results and emits exactly one single-cycle key event per physical key press. It sits between the combinational keypad decoder (`press`, 4-bit `scan_code`) and the six-digit key buffer/display chain. It runs in the slow keypad scan clock domain, the same clock that drives the row scanner. An optional auto-repeat generates further events while a key stays held.

## Interface
- `SCAN_ROWS`, 4: scan clocks per full keypad sweep (one evaluation window).
- `STABLE_WIN`, 3: consecutive matching windows required to accept a press (≥1).
- `REL_WIN`, 3: consecutive empty windows required to accept a release (≥1).
- `REPEAT_DLY`, 0: held windows before the first repeat event; 0 disables auto-repeat.
- `REPEAT_PER`, 4: held windows between later repeat events (≥1).

Ports:
- `clk` in 1: scan clock, same as the row scanner.
- `rst` in 1: asynchronous, active-low reset.
- `press` in 1: the decoder reports a key in the currently driven row.
- `scan_code` in 4: decoder key code; valid only while `press`=1.
- `key_valid` out 1: one-cycle event pulse.
- `key_code` out 4: code of the last event; held until the next event.
- `key_held` out 1: level, high from press acceptance until release acceptance.

## Operation
- **Window sampler.**
  - Phase counter runs 0..SCAN_ROWS-1 and wraps. It resets to 0 together with the row scanner so windows align with full sweeps.
  - Per window it records: seen (any `press`=1), the code (first code seen), and conflict (a later `press` cycle carries a different code).
  - At phase SCAN_ROWS-1 (that cycle's sample included) it issues one window result: PRESENT(code), or EMPTY. An EMPTY result covers no press, and also conflict (multi-key windows are rejected).
  - Window state clears for the next window.
- **FSM.** States IDLE, CONFIRM, HELD, RELEASE. It acts only on window results. One shared window counter `cnt` and one candidate code `cand`.
  - IDLE: PRESENT(c) → `cand`=c, `cnt`=1. If STABLE_WIN=1, accept; otherwise go to CONFIRM. EMPTY → stay.
  - CONFIRM: PRESENT(`cand`) → `cnt`+1. On reaching STABLE_WIN, accept. PRESENT(other) → `cand`=other, `cnt`=1, stay. EMPTY → IDLE.
  - Accept: pulse `key_valid`, `key_code`=`cand`, `key_held`=1, go to HELD, repeat counter `rc`=0.
  - HELD: PRESENT(`cand`) → `rc`+1. If REPEAT_DLY≠0 and `rc` reaches REPEAT_DLY (first) or REPEAT_PER (later), pulse `key_valid` with the same code and set `rc`=0. EMPTY or PRESENT(other) → RELEASE with `cnt`=1. If REL_WIN=1, release immediately.
  - RELEASE: PRESENT(`cand`) → back to HELD. This is a bounce: no event, and `rc` restarts at 0 against REPEAT_PER. EMPTY or PRESENT(other) → `cnt`+1. On reaching REL_WIN → IDLE with `key_held`=0.
- A different key pressed while one is held produces nothing until the first key is released. The new key is then qualified from IDLE.
- `cnt` and `rc` saturate and never wrap.

## Timing
- Reset values: `key_valid`=0, `key_code`=0, `key_held`=0, FSM=IDLE, phase=0, all counters 0.
- Reset is asynchronous. Asserting it mid-window or mid-confirmation discards all partial state with no event. The first window after deassertion starts at phase 0.
- Outputs are registered. The window result and the `key_valid`, `key_held` and `key_code` updates appear in the cycle after phase SCAN_ROWS-1.
- Press latency: key stable from a window start → `key_valid` high for exactly 1 cycle at clock STABLE_WIN×SCAN_ROWS after that start (default: clock 12).
- Release latency: `key_held` falls at clock REL_WIN×SCAN_ROWS after the start of the first empty window.
- `key_valid` never holds for two consecutive cycles. Events are separated by at least SCAN_ROWS cycles.

## Structure
- Shared package `keypad_pkg` holds:
  - the FSM state encoding (IDLE/CONFIRM/HELD/RELEASE, 2 bits);
  - the `KEY_CODE_W`=4 constant;
  - the default `SCAN_ROWS`, shared with the row scanner.
- One sub-module, `key_scan_window`: the phase counter, seen/code/conflict capture, and window-result strobe. The FSM, counters and output registers stay in `key_event_filter`.

## Test plan
- Reset, then key 0x5 held steady for 20 windows with defaults → exactly one `key_valid` at clock 12 with `key_code`=0x5. `key_held` rises at clock 12.
- Key 0x5 held for 2 windows, 1 empty window, then held for 3 windows → no event from the first burst; one event at the end of the sixth window.
- Held 0xA, one empty window, then 0xA again (bounce), then released for 3 windows → one event only. `key_held` falls 12 clocks after the final release begins.
- Two keys 0x1 and 0x7 seen in the same window, continuously → no event, `key_held` stays 0.
- REPEAT_DLY=8, REPEAT_PER=4, key 0x3 held for 20 windows → events at the ends of windows 3, 11, 15 and 19, all with code 0x3.
- `rst` asserted low at clock 10 of a qualifying press → outputs are 0 immediately. After release of reset, an event occurs 12 clocks into the held period only if the key is still held.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared keypad constants: key code width, default sweep length and the
// filter FSM state encoding.
package keypad_pkg;

    localparam int KEY_CODE_W        = 4;
    localparam int SCAN_ROWS_DEFAULT = 4;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_CONFIRM = 2'd1;
    localparam logic [1:0] ST_HELD    = 2'd2;
    localparam logic [1:0] ST_RELEASE = 2'd3;

endpackage

// File: rtl/key_scan_window.sv
// Collapses one full keypad sweep into a single window result: PRESENT(code)
// when exactly one key code was seen, otherwise EMPTY.
module key_scan_window
    import keypad_pkg::*;
#(
    parameter int SCAN_ROWS = SCAN_ROWS_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  press_i,
    input  logic [KEY_CODE_W-1:0] scan_code_i,
    output logic                  win_done_o,
    output logic                  win_present_o,
    output logic [KEY_CODE_W-1:0] win_code_o
);

    localparam int PH_W = (SCAN_ROWS > 1) ? $clog2(SCAN_ROWS) : 1;
    localparam logic [PH_W-1:0] LAST_PH = PH_W'(SCAN_ROWS - 1);

    logic [PH_W-1:0]       phase_q, phase_d;
    logic                  seen_q, seen_d;
    logic                  conf_q, conf_d;
    logic [KEY_CODE_W-1:0] code_q, code_d;
    logic                  seen_now_s, conf_now_s;
    logic [KEY_CODE_W-1:0] code_now_s;

    // Fold the current sample in so the last phase's sample counts toward its window.
    always_comb begin
        seen_now_s = seen_q | press_i;
        code_now_s = seen_q ? code_q : scan_code_i;
        conf_now_s = conf_q | (seen_q & press_i & (scan_code_i != code_q));

        win_done_o    = (phase_q == LAST_PH);
        win_present_o = seen_now_s & ~conf_now_s;
        win_code_o    = code_now_s;

        if (phase_q == LAST_PH) begin
            phase_d = {PH_W{1'b0}};
            seen_d  = 1'b0;
            conf_d  = 1'b0;
            code_d  = {KEY_CODE_W{1'b0}};
        end else begin
            phase_d = phase_q + PH_W'(1);
            seen_d  = seen_now_s;
            conf_d  = conf_now_s;
            code_d  = code_now_s;
        end
    end

    // Window capture registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase_q <= {PH_W{1'b0}};
            seen_q  <= 1'b0;
            conf_q  <= 1'b0;
            code_q  <= {KEY_CODE_W{1'b0}};
        end else begin
            phase_q <= phase_d;
            seen_q  <= seen_d;
            conf_q  <= conf_d;
            code_q  <= code_d;
        end
    end

endmodule

// File: rtl/key_event_filter.sv
// Debounce / de-duplicate keypad window results into single-cycle key events,
// with optional auto-repeat while a key stays held.
module key_event_filter
    import keypad_pkg::*;
#(
    parameter int SCAN_ROWS  = SCAN_ROWS_DEFAULT,
    parameter int STABLE_WIN = 3,
    parameter int REL_WIN    = 3,
    parameter int REPEAT_DLY = 0,
    parameter int REPEAT_PER = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  press,
    input  logic [KEY_CODE_W-1:0] scan_code,
    output logic                  key_valid,
    output logic [KEY_CODE_W-1:0] key_code,
    output logic                  key_held
);

    localparam int CNT_MAX = (STABLE_WIN > REL_WIN) ? STABLE_WIN : REL_WIN;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int RC_MAX  = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
    localparam int RC_W    = $clog2(RC_MAX + 1);
    localparam logic [CNT_W-1:0] STABLE_LIM = CNT_W'(STABLE_WIN);
    localparam logic [CNT_W-1:0] REL_LIM    = CNT_W'(REL_WIN);
    localparam logic [RC_W-1:0]  DLY_LIM    = RC_W'(REPEAT_DLY);
    localparam logic [RC_W-1:0]  PER_LIM    = RC_W'(REPEAT_PER);
    localparam logic             REPEAT_EN  = (REPEAT_DLY != 0);

    logic                  win_done_s, win_present_s, match_s, accept_s;
    logic [KEY_CODE_W-1:0] win_code_s;
    logic [1:0]            state_q, state_d;
    logic [KEY_CODE_W-1:0] cand_q, cand_d, key_code_q, key_code_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d, cnt_inc_s;
    logic [RC_W-1:0]       rc_q, rc_d, rc_inc_s, rc_lim_s;
    logic                  rep_q, rep_d, key_valid_q, key_valid_d, key_held_q, key_held_d;

    key_scan_window #(.SCAN_ROWS(SCAN_ROWS)) u_window (
        .clk           (clk),
        .rst           (rst),
        .press_i       (press),
        .scan_code_i   (scan_code),
        .win_done_o    (win_done_s),
        .win_present_o (win_present_s),
        .win_code_o    (win_code_s)
    );

    // Next-state logic; the FSM only moves on window results.
    always_comb begin
        state_d     = state_q;
        cand_d      = cand_q;
        cnt_d       = cnt_q;
        rc_d        = rc_q;
        rep_d       = rep_q;
        key_valid_d = 1'b0;
        key_code_d  = key_code_q;
        key_held_d  = key_held_q;
        accept_s    = 1'b0;
        match_s     = win_present_s && (win_code_s == cand_q);
        cnt_inc_s   = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
        rc_inc_s    = (rc_q == {RC_W{1'b1}}) ? rc_q : rc_q + RC_W'(1);
        rc_lim_s    = rep_q ? PER_LIM : DLY_LIM;

        if (win_done_s) begin
            case (state_q)
                ST_IDLE: begin
                    if (win_present_s) begin
                        cand_d = win_code_s;
                        cnt_d  = CNT_W'(1);
                        if (CNT_W'(1) >= STABLE_LIM) accept_s = 1'b1;
                        else                         state_d  = ST_CONFIRM;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_CONFIRM: begin
                    if (match_s) begin
                        cnt_d = cnt_inc_s;
                        if (cnt_inc_s >= STABLE_LIM) accept_s = 1'b1;
                        else                         accept_s = 1'b0;
                    end else if (win_present_s) begin
                        cand_d = win_code_s;
                        cnt_d  = CNT_W'(1);
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_HELD: begin
                    if (match_s) begin
                        // Auto-repeat: first event after REPEAT_DLY windows, then every REPEAT_PER.
                        if (REPEAT_EN && (rc_inc_s >= rc_lim_s)) begin
                            key_valid_d = 1'b1;
                            key_code_d  = cand_q;
                            rc_d        = {RC_W{1'b0}};
                            rep_d       = 1'b1;
                        end else begin
                            rc_d = rc_inc_s;
                        end
                    end else begin
                        cnt_d = CNT_W'(1);
                        if (CNT_W'(1) >= REL_LIM) begin
                            state_d    = ST_IDLE;
                            key_held_d = 1'b0;
                        end else begin
                            state_d = ST_RELEASE;
                        end
                    end
                end
                ST_RELEASE: begin
                    if (match_s) begin
                        state_d = ST_HELD;
                        rc_d    = {RC_W{1'b0}};
                        rep_d   = 1'b1;
                    end else if (cnt_inc_s >= REL_LIM) begin
                        state_d    = ST_IDLE;
                        cnt_d      = cnt_inc_s;
                        key_held_d = 1'b0;
                    end else begin
                        cnt_d = cnt_inc_s;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        if (accept_s) begin
            state_d     = ST_HELD;
            key_valid_d = 1'b1;
            key_code_d  = cand_d;
            key_held_d  = 1'b1;
            rc_d        = {RC_W{1'b0}};
            rep_d       = 1'b0;
        end
    end

    // FSM, counters and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            cand_q      <= {KEY_CODE_W{1'b0}};
            cnt_q       <= {CNT_W{1'b0}};
            rc_q        <= {RC_W{1'b0}};
            rep_q       <= 1'b0;
            key_valid_q <= 1'b0;
            key_code_q  <= {KEY_CODE_W{1'b0}};
            key_held_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cand_q      <= cand_d;
            cnt_q       <= cnt_d;
            rc_q        <= rc_d;
            rep_q       <= rep_d;
            key_valid_q <= key_valid_d;
            key_code_q  <= key_code_d;
            key_held_q  <= key_held_d;
        end
    end

    assign key_valid = key_valid_q;
    assign key_code  = key_code_q;
    assign key_held  = key_held_q;

endmodule

// File: tb/tb_key_event_filter.sv
// Bench for key_event_filter: a default instance and an auto-repeat instance
// driven in parallel and compared every cycle against a window-level model.
module tb_key_event_filter;

    localparam int M_IDLE = 0, M_CONF = 1, M_HELD = 2, M_REL = 3;

    typedef struct {
        int         mode;
        int         cnt;
        int         rc;
        bit         rep;
        bit         held;
        bit         valid;
        logic [3:0] cand;
        logic [3:0] code;
    } mdl_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       press = 1'b0;
    logic [3:0] scan_code = 4'h0;
    logic       va, ha, vb, hb;
    logic [3:0] ca, cb;

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   phase = 0;
    bit   wp [4];
    logic [3:0] wc [4];
    mdl_t ma, mb;
    int   ev_a[$], ev_b[$], rise_a[$], fall_a[$];
    bit   prev_ha;

    always #5 clk = ~clk;

    key_event_filter dut_a (
        .clk(clk), .rst(rst), .press(press), .scan_code(scan_code),
        .key_valid(va), .key_code(ca), .key_held(ha)
    );

    key_event_filter #(.REPEAT_DLY(8), .REPEAT_PER(4)) dut_b (
        .clk(clk), .rst(rst), .press(press), .scan_code(scan_code),
        .key_valid(vb), .key_code(cb), .key_held(hb)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic mdl_t mdl_window(mdl_t s, bit pres, logic [3:0] code,
                                        int sw, int rw, int rd, int rp);
        bit same;
        same    = pres && (code == s.cand);
        s.valid = 1'b0;
        case (s.mode)
            M_IDLE: if (pres) begin s.cand = code; s.cnt = 0; s.mode = M_CONF; end
            M_CONF: if (!pres) s.mode = M_IDLE;
                    else if (!same) begin s.cand = code; s.cnt = 0; end
            M_HELD: if (same) begin
                        s.rc = s.rc + 1;
                        if (rd != 0 && s.rc >= (s.rep ? rp : rd)) begin
                            s.valid = 1'b1; s.rc = 0; s.rep = 1'b1;
                        end
                    end else begin
                        s.mode = M_REL; s.cnt = 0;
                    end
            default: if (same) begin s.mode = M_HELD; s.rc = 0; s.rep = 1'b1; end
        endcase
        if (s.mode == M_CONF) begin
            s.cnt = s.cnt + 1;
            if (s.cnt >= sw) begin
                s.mode = M_HELD; s.valid = 1'b1; s.code = s.cand;
                s.held = 1'b1; s.rc = 0; s.rep = 1'b0;
            end
        end else if (s.mode == M_REL) begin
            s.cnt = s.cnt + 1;
            if (s.cnt >= rw) begin s.mode = M_IDLE; s.held = 1'b0; end
        end
        return s;
    endfunction

    task automatic mdl_reset();
        ma = '{mode: M_IDLE, cnt: 0, rc: 0, rep: 1'b0, held: 1'b0, valid: 1'b0,
               cand: 4'h0, code: 4'h0};
        mb = ma;
        phase = 0;
        cyc = 0;
        prev_ha = 1'b0;
        ev_a.delete(); ev_b.delete(); rise_a.delete(); fall_a.delete();
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst = 1'b1;
        mdl_reset();
    endtask

    task automatic do_reset();
        press = 1'b0;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        release_reset();
    endtask

    // One scan clock: drive, model the sample, compare both instances.
    task automatic step(input bit p, input logic [3:0] c);
        bit pres, conf;
        logic [3:0] wcode;
        press = p;
        scan_code = c;
        @(posedge clk);
        #1;
        wp[phase] = p;
        wc[phase] = c;
        if (phase == 3) begin
            pres = 1'b0; conf = 1'b0; wcode = 4'h0;
            for (int i = 0; i < 4; i++) begin
                if (wp[i]) begin
                    if (!pres) begin pres = 1'b1; wcode = wc[i]; end
                    else if (wc[i] != wcode) conf = 1'b1;
                end
            end
            pres = pres && !conf;
            ma = mdl_window(ma, pres, wcode, 3, 3, 0, 4);
            mb = mdl_window(mb, pres, wcode, 3, 3, 8, 4);
            phase = 0;
        end else begin
            ma.valid = 1'b0;
            mb.valid = 1'b0;
            phase++;
        end
        checks += 6;
        if (va !== ma.valid) begin failures++; $display("FAIL a_valid clk=%0d got=%b exp=%b", cyc + 1, va, ma.valid); end
        if (ca !== ma.code)  begin failures++; $display("FAIL a_code clk=%0d got=%h exp=%h", cyc + 1, ca, ma.code); end
        if (ha !== ma.held)  begin failures++; $display("FAIL a_held clk=%0d got=%b exp=%b", cyc + 1, ha, ma.held); end
        if (vb !== mb.valid) begin failures++; $display("FAIL b_valid clk=%0d got=%b exp=%b", cyc + 1, vb, mb.valid); end
        if (cb !== mb.code)  begin failures++; $display("FAIL b_code clk=%0d got=%h exp=%h", cyc + 1, cb, mb.code); end
        if (hb !== mb.held)  begin failures++; $display("FAIL b_held clk=%0d got=%b exp=%b", cyc + 1, hb, mb.held); end
        if (va === 1'b1) ev_a.push_back(cyc + 1);
        if (vb === 1'b1) ev_b.push_back(cyc + 1);
        if (ha === 1'b1 && !prev_ha) rise_a.push_back(cyc + 1);
        if (ha === 1'b0 && prev_ha)  fall_a.push_back(cyc + 1);
        prev_ha = (ha === 1'b1);
        cyc++;
    endtask

    task automatic test_reset();
        #1;
        checks += 3;
        if ({va, vb} !== 2'b00) begin failures++; $display("FAIL reset_valid got=%b%b exp=00", va, vb); end
        if ({ha, hb} !== 2'b00) begin failures++; $display("FAIL reset_held got=%b%b exp=00", ha, hb); end
        if ({ca, cb} !== 8'h00) begin failures++; $display("FAIL reset_code got=%h%h exp=00", ca, cb); end
        do_reset();
    endtask

    task automatic test_steady();
        do_reset();
        for (int i = 0; i < 80; i++) step(1'b1, 4'h5);
        checks += 3;
        if (ev_a.size() != 1 || ev_a[0] != 12) begin failures++; $display("FAIL steady_event n=%0d first=%0d exp=1@12", ev_a.size(), ev_a[0]); end
        if (rise_a.size() != 1 || rise_a[0] != 12) begin failures++; $display("FAIL steady_held_rise n=%0d at=%0d exp=1@12", rise_a.size(), rise_a[0]); end
        if (ca !== 4'h5) begin failures++; $display("FAIL steady_code got=%h exp=5", ca); end
    endtask

    task automatic test_broken_burst();
        do_reset();
        for (int i = 0; i < 8; i++)  step(1'b1, 4'h5);
        for (int i = 0; i < 4; i++)  step(1'b0, 4'h5);
        for (int i = 0; i < 12; i++) step(1'b1, 4'h5);
        checks += 1;
        if (ev_a.size() != 1 || ev_a[0] != 24) begin failures++; $display("FAIL burst_event n=%0d first=%0d exp=1@24", ev_a.size(), ev_a[0]); end
    endtask

    task automatic test_bounce();
        do_reset();
        for (int i = 0; i < 16; i++) step(1'b1, 4'hA);
        for (int i = 0; i < 4; i++)  step(1'b0, 4'h0);
        for (int i = 0; i < 4; i++)  step(1'b1, 4'hA);
        for (int i = 0; i < 16; i++) step(1'b0, 4'h0);
        checks += 2;
        if (ev_a.size() != 1) begin failures++; $display("FAIL bounce_events got=%0d exp=1", ev_a.size()); end
        if (fall_a.size() != 1 || fall_a[0] != 36) begin failures++; $display("FAIL bounce_release n=%0d at=%0d exp=1@36", fall_a.size(), fall_a[0]); end
    endtask

    task automatic test_two_keys();
        do_reset();
        for (int i = 0; i < 40; i++) step(1'b1, (i % 2 == 0) ? 4'h1 : 4'h7);
        checks += 2;
        if (ev_a.size() != 0 || ev_b.size() != 0) begin failures++; $display("FAIL two_keys_events got=%0d/%0d exp=0", ev_a.size(), ev_b.size()); end
        if (ha !== 1'b0) begin failures++; $display("FAIL two_keys_held got=%b exp=0", ha); end
    endtask

    task automatic test_repeat();
        do_reset();
        for (int i = 0; i < 80; i++) step(1'b1, 4'h3);
        checks += 3;
        if (ev_b.size() != 4 || ev_b[0] != 12 || ev_b[1] != 44 || ev_b[2] != 60 || ev_b[3] != 76) begin
            failures++;
            $display("FAIL repeat_events n=%0d at=%0d,%0d,%0d,%0d exp=12,44,60,76", ev_b.size(), ev_b[0], ev_b[1], ev_b[2], ev_b[3]);
        end
        if (cb !== 4'h3) begin failures++; $display("FAIL repeat_code got=%h exp=3", cb); end
        if (ev_a.size() != 1) begin failures++; $display("FAIL repeat_off_events got=%0d exp=1", ev_a.size()); end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 0; i < 16; i++) step(1'b1, 4'h5);
        #2 rst = 1'b0;
        #1;
        checks += 2;
        if ({ha, hb} !== 2'b00) begin failures++; $display("FAIL async_held got=%b%b exp=00", ha, hb); end
        if ({ca, cb} !== 8'h00) begin failures++; $display("FAIL async_code got=%h%h exp=00", ca, cb); end
        release_reset();
        for (int i = 0; i < 10; i++) step(1'b1, 4'h5);
        #2 rst = 1'b0;
        #1;
        checks += 1;
        if ({va, ha, ca} !== 6'h00) begin failures++; $display("FAIL midpress_outputs got=%b%b%h exp=000", va, ha, ca); end
        release_reset();
        for (int i = 0; i < 16; i++) step(1'b1, 4'h5);
        checks += 1;
        if (ev_a.size() != 1 || ev_a[0] != 12) begin failures++; $display("FAIL reset_still_held n=%0d at=%0d exp=1@12", ev_a.size(), ev_a[0]); end
        for (int i = 0; i < 6; i++) step(1'b1, 4'h5);
        #2 rst = 1'b0;
        release_reset();
        for (int i = 0; i < 20; i++) step(1'b0, 4'h5);
        checks += 1;
        if (ev_a.size() != 0) begin failures++; $display("FAIL reset_released_events got=%0d exp=0", ev_a.size()); end
    endtask

    task automatic test_random();
        int kind, len;
        logic [3:0] k1, k2;
        do_reset();
        for (int s = 0; s < 60; s++) begin
            kind = $urandom_range(0, 3);
            len  = $urandom_range(1, 24);
            k1   = 4'($urandom_range(0, 15));
            k2   = k1 + 4'($urandom_range(1, 15));
            for (int i = 0; i < len; i++) begin
                case (kind)
                    0: step(1'b1, k1);
                    1: step(1'b0, k2);
                    2: step(1'($urandom_range(0, 1)), k1);
                    default: step(1'b1, ($urandom_range(0, 3) == 0) ? k2 : k1);
                endcase
            end
        end
    endtask

    initial begin
        test_reset();
        test_steady();
        test_broken_burst();
        test_bounce();
        test_two_keys();
        test_repeat();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
